// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide controller: funct3 op codes, bus widths
// and FSM state encodings.
package div_ctrl_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_ctrl.sv
// Divide-instruction sequencer: latches operands, drives the external divider,
// buffers its result and hands it to write-back, with flush and watchdog abort.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [2:0]            op_i,
  input  logic [RegBus-1:0]     rs1_i,
  input  logic [RegBus-1:0]     rs2_i,
  input  logic [RegAddrBus-1:0] rd_i,
  input  logic                  flush_i,
  output logic                  div_start_o,
  output logic [2:0]            div_op_o,
  output logic [RegBus-1:0]     div_dividend_o,
  output logic [RegBus-1:0]     div_divisor_o,
  output logic [RegAddrBus-1:0] div_waddr_o,
  input  logic [RegBus-1:0]     div_result_i,
  input  logic                  div_ready_i,
  output logic                  hold_o,
  output logic                  wb_valid_o,
  output logic [RegAddrBus-1:0] wb_waddr_o,
  output logic [RegBus-1:0]     wb_wdata_o,
  input  logic                  wb_ready_i,
  output logic                  timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  div_state_e        state;
  logic [CW-1:0]     cnt;
  logic [RegBus-1:0] result;
  logic              tmo_hit;

  // Watchdog fires only when nothing better (flush or ready) happens this cycle.
  assign tmo_hit = (state == S_RUN) && !flush_i && !div_ready_i &&
                   (cnt == CW'(TIMEOUT - 1));

  // Start drops in the ready cycle so the divider cannot relaunch on that edge.
  assign div_start_o = (state == S_RUN) && !div_ready_i && !flush_i && !tmo_hit;
  assign hold_o      = (state != S_IDLE) || (req_i && !flush_i);
  assign wb_valid_o  = (state == S_WB);
  assign wb_waddr_o  = div_waddr_o;
  assign wb_wdata_o  = result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      result         <= '0;
      div_op_o       <= '0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      div_waddr_o    <= '0;
      timeout_o      <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i && !flush_i) begin
            div_op_o       <= op_i;
            div_dividend_o <= rs1_i;
            div_divisor_o  <= rs2_i;
            div_waddr_o    <= rd_i;
            cnt            <= '0;
            state          <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (flush_i) begin
            state <= S_IDLE;
          end else if (div_ready_i) begin
            result <= div_result_i;
            state  <= S_WB;
          end else if (tmo_hit) begin
            timeout_o <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_WB: begin
          if (flush_i || wb_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl with a behavioural divider stub; directed
// vectors push hand-computed write-back values, a monitor pops at handshake.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0, flush_i = 1'b0, wb_ready_i = 1'b1;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0, rs2_i = '0, div_result_i = '0;
  logic [4:0]  rd_i = '0;
  logic        div_ready_i = 1'b0;
  logic        div_start_o, hold_o, wb_valid_o, timeout_o;
  logic [2:0]  div_op_o;
  logic [31:0] div_dividend_o, div_divisor_o, wb_wdata_o;
  logic [4:0]  div_waddr_o, wb_waddr_o;

  int checks = 0, errors = 0;
  int stub_en = 1, lat_norm = 20, scnt = 0, start_cycles = 0;

  typedef struct { logic [4:0] waddr; logic [31:0] wdata; } wb_t;
  wb_t exp_q[$];

  always #5 clk = ~clk;

  div_ctrl #(.TIMEOUT(48)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i), .div_start_o(div_start_o),
    .div_op_o(div_op_o), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_waddr_o(div_waddr_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i), .hold_o(hold_o),
    .wb_valid_o(wb_valid_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .wb_ready_i(wb_ready_i), .timeout_o(timeout_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // RISC-V divide semantics, including divide-by-zero and signed overflow.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q;
    sa = a; sb = b;
    case (op)
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Divider stub: ready for one cycle after lat start cycles (2 for zero divisor).
  always @(negedge clk) begin
    if (div_ready_i) begin
      div_ready_i = 1'b0;
      scnt = 0;
    end else if (div_start_o) begin
      scnt++;
      start_cycles++;
      if (stub_en != 0 && scnt >= ((div_divisor_o == 0) ? 2 : lat_norm)) begin
        div_result_i = ref_div(div_op_o, div_dividend_o, div_divisor_o);
        div_ready_i = 1'b1;
        #1 chk("start_low_on_ready", div_start_o, 0);
      end
    end else begin
      scnt = 0;
    end
  end

  always @(negedge clk) begin
    if (rst && wb_valid_o && wb_ready_i && !flush_i) begin
      wb_t e;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wb: got waddr %0d data %h, required no write-back", wb_waddr_o, wb_wdata_o);
      end else begin
        e = exp_q.pop_front();
        chk("wb_waddr", wb_waddr_o, e.waddr);
        chk("wb_wdata", wb_wdata_o, e.wdata);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(posedge clk); #1;
    drive(op, a, b, rd);
    @(posedge clk); #1;
    req_i = 1'b0;
    start_cycles = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (hold_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk({name, "_idle_timeout"}, hold_o, 0);
  endtask

  task automatic wait_wb(input string name);
    int n = 0;
    @(negedge clk);
    while (!wb_valid_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk({name, "_wb_timeout"}, wb_valid_o, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_start"}, div_start_o, 0);
    chk({tag, "_hold"}, hold_o, 0);
    chk({tag, "_wb_valid"}, wb_valid_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
    chk({tag, "_op"}, div_op_o, 0);
    chk({tag, "_dividend"}, div_dividend_o, 0);
    chk({tag, "_divisor"}, div_divisor_o, 0);
    chk({tag, "_waddr"}, div_waddr_o, 0);
    chk({tag, "_wb_waddr"}, wb_waddr_o, 0);
    chk({tag, "_wb_wdata"}, wb_wdata_o, 0);
  endtask

  initial begin
    int run, tcnt;
    #12 check_zero("rst");

    // First request accepted on the first edge after release; DIV 100/7.
    @(posedge clk); #1;
    rst = 1'b1;
    drive(INST_DIV, 32'd100, 32'd7, 5'd5);
    exp_q.push_back('{5'd5, 32'd14});
    #1 chk("hold_idle_req", hold_o, 1);
    @(posedge clk); #1;
    req_i = 1'b0; start_cycles = 0;
    chk("first_start", div_start_o, 1);
    chk("latch_op", div_op_o, 3'b100);
    chk("latch_dividend", div_dividend_o, 100);
    chk("latch_divisor", div_divisor_o, 7);
    chk("latch_rd", div_waddr_o, 5);
    wait_idle("div100_7");

    exp_q.push_back('{5'd3, 32'hFFFF_FFFF});
    issue(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd3);
    wait_idle("rem");

    exp_q.push_back('{5'd4, 32'hFFFF_FFFF});
    issue(INST_DIVU, 32'd123, 32'd0, 5'd4);
    wait_idle("divu0");
    chk("divu0_start_cycles", start_cycles, 2);

    // Flush in RUN cycle 10: start drops at once, no write-back follows.
    issue(INST_DIV, 32'd1000, 32'd10, 5'd11);
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    #1 chk("flush_run_start", div_start_o, 0);
    chk("flush_run_hold", hold_o, 1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_run_hold_next", hold_o, 0);
    chk("flush_run_wb_valid", wb_valid_o, 0);

    // Write-back stall: outputs stable, new request ignored.
    wb_ready_i = 1'b0;
    exp_q.push_back('{5'd7, 32'd10});
    issue(INST_DIV, 32'd50, 32'd5, 5'd7);
    wait_wb("stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(INST_DIVU, 32'd1, 32'd1, 5'd9);
      #1;
      chk("stall_valid", wb_valid_o, 1);
      chk("stall_wdata", wb_wdata_o, 10);
      chk("stall_waddr", wb_waddr_o, 7);
      chk("stall_hold", hold_o, 1);
    end
    req_i = 1'b0;
    wb_ready_i = 1'b1;
    wait_idle("stall");
    chk("stall_no_relatch", div_waddr_o, 7);

    // Flush in WB drops the buffered result.
    wb_ready_i = 1'b0;
    issue(INST_DIV, 32'd8, 32'd2, 5'd12);
    wait_wb("flush_wb");
    @(posedge clk); #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    chk("flush_wb_valid", wb_valid_o, 0);
    chk("flush_wb_hold", hold_o, 0);
    wb_ready_i = 1'b1;

    // Request with flush in IDLE is not accepted.
    @(posedge clk); #1;
    drive(INST_DIV, 32'd77, 32'd7, 5'd31);
    flush_i = 1'b1;
    #1 chk("idle_flush_hold", hold_o, 0);
    @(posedge clk); #1;
    req_i = 1'b0; flush_i = 1'b0;
    #1 chk("idle_flush_state", hold_o, 0);
    chk("idle_flush_no_latch", div_waddr_o, 12);

    // Watchdog: divider never answers.
    stub_en = 0;
    issue(INST_DIV, 32'd5, 32'd1, 5'd2);
    run = 0; tcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (hold_o) run++;
      if (timeout_o) tcnt++;
    end
    chk("tmo_run_cycles", run, 48);
    chk("tmo_pulses", tcnt, 1);
    chk("tmo_idle", hold_o, 0);
    stub_en = 1;

    // Asynchronous reset mid-RUN, then DIV 9/3.
    issue(INST_DIV, 32'd20, 32'd4, 5'd6);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero("midrst");
    @(posedge clk); #1 rst = 1'b1;
    exp_q.push_back('{5'd8, 32'd3});
    issue(INST_DIV, 32'd9, 32'd3, 5'd8);
    wait_idle("div9_3");

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
